seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operand handshake in, result handshake out.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative non-restoring radix-2 unsigned divider: one quotient bit per cycle plus a
// remainder-correction cycle. Optional macro SEQ_DIVIDER_ZERO_SKIP_EN short-cuts divide-by-zero.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt_r;
  logic             dbz_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;

  logic [WIDTH:0]   d_ext_s;
  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH:0]   p_step_s;
  logic [WIDTH:0]   p_fix_s;
  logic [WIDTH-1:0] q_step_s;
  logic             accept_s;
  logic             zero_div_s;

  assign d_ext_s    = {1'b0, d_r};
  assign accept_s   = bus.in_valid & in_ready_r & (state_r == IDLE);
  assign zero_div_s = (bus.divisor == {WIDTH{1'b0}});

  // One non-restoring step plus the final remainder correction; the sign of P picks add or subtract.
  always_comb begin
    p_shift_s = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    p_step_s  = {(WIDTH+1){1'b0}};
    p_fix_s   = p_r;
    if (p_r[WIDTH]) begin
      p_step_s = p_shift_s + d_ext_s;
    end else begin
      p_step_s = p_shift_s - d_ext_s;
    end
    q_step_s = {q_r[WIDTH-2:0], ~p_step_s[WIDTH]};
    if (p_r[WIDTH]) begin
      p_fix_s = p_r + d_ext_s;
    end else begin
      p_fix_s = p_r;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      p_r           <= {(WIDTH+1){1'b0}};
      q_r           <= {WIDTH{1'b0}};
      d_r           <= {WIDTH{1'b0}};
      cnt_r         <= {CW{1'b0}};
      dbz_r         <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            q_r        <= bus.dividend;
            d_r        <= bus.divisor;
            p_r        <= {(WIDTH+1){1'b0}};
            cnt_r      <= CNT_INIT;
            dbz_r      <= zero_div_s;
            in_ready_r <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_SKIP_EN
            if (zero_div_s) begin
              // out_valid follows one cycle later from DONE
              state_r       <= DONE;
              quotient_r    <= {WIDTH{1'b1}};
              remainder_r   <= bus.dividend;
              div_by_zero_r <= 1'b1;
            end else begin
              state_r <= BUSY;
            end
`else
            state_r <= BUSY;
`endif
          end
        end
        BUSY: begin
          p_r <= p_step_s;
          q_r <= q_step_s;
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          p_r           <= p_fix_s;
          quotient_r    <= q_r;
          remainder_r   <= p_fix_s[WIDTH-1:0];
          div_by_zero_r <= dbz_r;
          out_valid_r   <= 1'b1;
          state_r       <= DONE;
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider at WIDTH 3, 7, 8 and 13 sharing one stimulus port.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int sel = 8;

  logic        tb_in_valid;
  logic        tb_out_ready;
  logic [15:0] tb_dividend;
  logic [15:0] tb_divisor;

  logic        o_in_ready;
  logic        o_out_valid;
  logic        o_dbz;
  logic [15:0] o_q;
  logic [15:0] o_r;

  seq_divider_if #(.WIDTH(3))  bi3 ();
  seq_divider_if #(.WIDTH(7))  bi7 ();
  seq_divider_if #(.WIDTH(8))  bi8 ();
  seq_divider_if #(.WIDTH(13)) bi13 ();

  seq_divider #(.WIDTH(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(bi3));
  seq_divider #(.WIDTH(7))  dut7  (.clk(clk), .rst_n(rst_n), .bus(bi7));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bi8));
  seq_divider #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bi13));

  assign bi3.in_valid   = tb_in_valid && (sel == 3);
  assign bi3.out_ready  = tb_out_ready && (sel == 3);
  assign bi3.dividend   = tb_dividend[2:0];
  assign bi3.divisor    = tb_divisor[2:0];
  assign bi7.in_valid   = tb_in_valid && (sel == 7);
  assign bi7.out_ready  = tb_out_ready && (sel == 7);
  assign bi7.dividend   = tb_dividend[6:0];
  assign bi7.divisor    = tb_divisor[6:0];
  assign bi8.in_valid   = tb_in_valid && (sel == 8);
  assign bi8.out_ready  = tb_out_ready && (sel == 8);
  assign bi8.dividend   = tb_dividend[7:0];
  assign bi8.divisor    = tb_divisor[7:0];
  assign bi13.in_valid  = tb_in_valid && (sel == 13);
  assign bi13.out_ready = tb_out_ready && (sel == 13);
  assign bi13.dividend  = tb_dividend[12:0];
  assign bi13.divisor   = tb_divisor[12:0];

  always_comb begin
    case (sel)
      3: begin
        o_in_ready = bi3.in_ready;  o_out_valid = bi3.out_valid; o_dbz = bi3.div_by_zero;
        o_q = 16'(bi3.quotient);    o_r = 16'(bi3.remainder);
      end
      7: begin
        o_in_ready = bi7.in_ready;  o_out_valid = bi7.out_valid; o_dbz = bi7.div_by_zero;
        o_q = 16'(bi7.quotient);    o_r = 16'(bi7.remainder);
      end
      13: begin
        o_in_ready = bi13.in_ready; o_out_valid = bi13.out_valid; o_dbz = bi13.div_by_zero;
        o_q = 16'(bi13.quotient);   o_r = 16'(bi13.remainder);
      end
      default: begin
        o_in_ready = bi8.in_ready;  o_out_valid = bi8.out_valid; o_dbz = bi8.div_by_zero;
        o_q = 16'(bi8.quotient);    o_r = 16'(bi8.remainder);
      end
    endcase
  end

  function automatic int exp_latency(input int w, input logic [15:0] b);
    int l;
    l = w + 1;
`ifdef SEQ_DIVIDER_ZERO_SKIP_EN
    if (b == 16'd0) l = 1;
`endif
    return l;
  endfunction

  // One full transaction from IDLE; entered and left at #1 after a rising edge.
  task automatic do_div(input int w, input logic [15:0] a, input logic [15:0] b, input string name);
    logic [15:0] mask, eq, er;
    logic        edbz;
    int          lat;
    mask = 16'((17'd1 << w) - 17'd1);
    if (b == 16'd0) begin
      eq = mask; er = a; edbz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0;
    end
    sel = w; tb_out_ready = 1'b1;
    tb_dividend = a; tb_divisor = b; tb_in_valid = 1'b1;
    lat = 0;
    while (!o_in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    total++;
    if (o_in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready timeout got=%b want=1", name, o_in_ready);
      tb_in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat !== exp_latency(w, b)) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_latency(w, b));
    end
    total++;
    if ({o_q, o_r, o_dbz} !== {eq, er, edbz}) begin
      bad++; $display("FAIL %s result got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                      name, o_q, o_r, o_dbz, eq, er, edbz);
    end
    @(posedge clk); #1;
    total++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      bad++; $display("FAIL %s post-handshake got valid=%b ready=%b want valid=0 ready=1",
                      name, o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    tb_dividend = 16'd0; tb_divisor = 16'd0; sel = 8;
    #12;
    total++;
    if ({o_out_valid, o_q, o_r, o_dbz} !== {1'b0, 16'd0, 16'd0, 1'b0}) begin
      bad++; $display("FAIL reset_outputs got valid=%b q=%0d r=%0d dbz=%b want all 0",
                      o_out_valid, o_q, o_r, o_dbz);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({o_in_ready, o_out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0",
                      o_in_ready, o_out_valid);
    end
  endtask

  task automatic test_basic();
    do_div(8, 16'd200, 16'd7, "200/7");
  endtask

  task automatic test_corners();
    do_div(8, 16'd255, 16'd1, "255/1");
    do_div(8, 16'd5, 16'd9, "5/9");
    do_div(8, 16'd0, 16'd3, "0/3");
    do_div(8, 16'd255, 16'd255, "255/255");
  endtask

  task automatic test_div_zero();
    do_div(8, 16'd77, 16'd0, "77/0");
    do_div(3, 16'd5, 16'd0, "w3_5/0");
  endtask

  task automatic test_hold();
    int lat;
    sel = 7; tb_out_ready = 1'b0;
    tb_dividend = 16'd100; tb_divisor = 16'd11; tb_in_valid = 1'b1;
    total++;
    if (o_in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_idle_ready got=%b want=1", o_in_ready);
    end
    @(posedge clk); #1;
    lat = 0;
    while (!o_out_valid && lat < 100) begin
      total++;
      if (o_in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_busy_ready cycle=%0d got=%b want=0", lat, o_in_ready);
      end
      tb_in_valid = ~tb_in_valid;
      tb_dividend = 16'd3 + 16'(lat);
      tb_divisor  = 16'd1;
      @(posedge clk); #1; lat++;
    end
    tb_in_valid = 1'b0;
    total++;
    if (lat !== 8) begin
      bad++; $display("FAIL hold_latency got=%0d want=8", lat);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({o_out_valid, o_in_ready, o_q, o_r, o_dbz} !== {1'b1, 1'b0, 16'd9, 16'd1, 1'b0}) begin
        bad++; $display("FAIL hold_stable cycle=%0d got valid=%b ready=%b q=%0d r=%0d want valid=1 ready=0 q=9 r=1",
                        i, o_out_valid, o_in_ready, o_q, o_r);
      end
      @(posedge clk); #1;
    end
    tb_out_ready = 1'b1;
    total++;
    if (o_in_ready !== 1'b0) begin
      bad++; $display("FAIL hold_pre_handshake_ready got=%b want=0", o_in_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      bad++; $display("FAIL hold_post_handshake got valid=%b ready=%b want valid=0 ready=1",
                      o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_reset_mid();
    sel = 8; tb_out_ready = 1'b1;
    tb_dividend = 16'd200; tb_divisor = 16'd7; tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_out_valid, o_q, o_r, o_dbz} !== {1'b0, 16'd0, 16'd0, 1'b0}) begin
      bad++; $display("FAIL midreset_outputs got valid=%b q=%0d r=%0d dbz=%b want all 0",
                      o_out_valid, o_q, o_r, o_dbz);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_div(8, 16'd100, 16'd10, "after_reset_100/10");
  endtask

  task automatic test_back_to_back(input int w, input int n);
    logic [15:0] mask, a, b, eq, er;
    logic        edbz;
    int          k, lat, prev_lat, period_bad, errs;
    time         acc_t, prev_t;
    mask = 16'((17'd1 << w) - 17'd1);
    sel = w; tb_out_ready = 1'b1; tb_in_valid = 1'b1;
    period_bad = 0; errs = 0; prev_lat = 0; prev_t = 0;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom) & mask;
      b = ($urandom_range(0, 15) == 0) ? 16'd0 : (16'($urandom) & mask);
      tb_dividend = a; tb_divisor = b;
      k = 0;
      while (!o_in_ready && k < 50) begin @(posedge clk); #1; k++; end
      @(posedge clk);
      acc_t = $time;
      #1;
      if (i > 0 && (acc_t - prev_t) != time'((prev_lat + 2) * 10)) period_bad++;
      prev_t = acc_t;
      prev_lat = exp_latency(w, b);
      lat = 0;
      while (!o_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (b == 16'd0) begin
        eq = mask; er = a; edbz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edbz = 1'b0;
      end
      total++;
      if ({o_out_valid, o_q, o_r, o_dbz} !== {1'b1, eq, er, edbz} ||
          (b != 16'd0 && (32'(o_q) * 32'(b) + 32'(o_r) != 32'(a) || o_r >= b))) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL sweep_w%0d %0d/%0d got valid=%b q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                   w, a, b, o_out_valid, o_q, o_r, o_dbz, eq, er, edbz);
      end
    end
    tb_in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (period_bad != 0) begin
      bad++; $display("FAIL sweep_w%0d_throughput bad_periods=%0d want 0", w, period_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_hold();
    test_reset_mid();
    test_back_to_back(3, 1000);
    test_back_to_back(8, 1000);
    test_back_to_back(13, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
